// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: groups the data-memory debug read port and the dump stream.
//   master side (controller): drives mem_rd_en, mem_addr, dump_valid,
//                             dump_data and dump_last; receives mem_rdata
//                             and dump_ready.
//   slave side (memory + sink): the mirror image.
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [31:0]       dump_data;
  logic              dump_last;

  modport master (
    output mem_rd_en, mem_addr, dump_valid, dump_data, dump_last,
    input  mem_rdata, dump_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, dump_valid, dump_data, dump_last,
    output mem_rdata, dump_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: runs a CPU until it sees a halt word in ID, lets the pipeline
// drain for DRAIN_CYCLES, then streams the whole data memory out over a
// valid/ready port and parks in DONE until reset.
//   clk         rising-edge system clock
//   reset       asynchronous, active-low
//   start       one-cycle run request, honoured only in IDLE
//   instr_id    instruction currently in the CPU ID stage
//   cpu_en      CPU clock-enable (RUN and DRAIN)
//   done        run and dump complete
//   cycle_count cpu_en=1 cycles since start, saturating
//   bus         memory read port + dump stream (cpu_run_ctrl_if.master)
module cpu_run_ctrl #(
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 10,
  parameter int          MEM_DEPTH    = 512,
  parameter int          ADDR_W       = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [31:0]    instr_id,
  output logic           cpu_en,
  output logic           done,
  output logic [31:0]    cycle_count,
  cpu_run_ctrl_if.master bus
);

  localparam int               CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(MEM_DEPTH - 1);
  localparam logic [7:0]       DRAIN_LOAD = 8'(DRAIN_CYCLES);
  // Words that may be owed to the sink at once: output register + 2 skid slots.
  localparam logic [1:0]       CREDIT_MAX = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         drain_r, drain_s;
  logic               cpu_en_r;
  logic               done_r;
  logic [31:0]        cycle_r;

  logic               rd_en_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               rd_last_r;
  logic               pend_r;
  logic               pend_last_r;
  logic [CNT_W-1:0]   rd_cnt_r;
  logic [1:0]         cred_r;

  logic               out_valid_r;
  logic [31:0]        out_data_r;
  logic               out_last_r;
  logic [31:0]        sk_data_r [0:1];
  logic               sk_last_r [0:1];
  logic               sk_wp_r;
  logic               sk_rp_r;
  logic [1:0]         sk_cnt_r;

  logic               hs_s;
  logic               out_free_s;
  logic [1:0]         cred_avail_s;
  logic               issue_s;
  logic               pop_s;
  logic               push_s;

  // Dump-path handshake, read-issue decision and skid push/pop.
  always_comb begin
    hs_s         = out_valid_r & bus.dump_ready;
    out_free_s   = ~out_valid_r | hs_s;
    cred_avail_s = cred_r - {1'b0, hs_s};
    issue_s      = 1'b0;
    // A read is only launched when every word it could add still has a slot,
    // assuming the sink stalls from now on; this keeps the stream lossless.
    if ((state_r == ST_DUMP) && (rd_cnt_r != DEPTH_CNT) && (cred_avail_s < CREDIT_MAX)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    pop_s  = out_free_s & (sk_cnt_r != 2'd0);
    // Returning data bypasses the skid only when the skid is empty and the
    // output register is free this cycle.
    push_s = pend_r & ~(out_free_s & (sk_cnt_r == 2'd0));
  end

  // Next-state logic for the run/drain/dump sequence.
  always_comb begin
    state_s = state_r;
    drain_s = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (instr_id == HALT_INSTR) begin
          state_s = ST_DRAIN;
          drain_s = DRAIN_LOAD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // instr_id is deliberately not looked at here.
        if (drain_r <= 8'd1) begin
          state_s = ST_DUMP;
          drain_s = 8'd0;
        end else begin
          drain_s = drain_r - 8'd1;
        end
      end
      ST_DUMP: begin
        if (hs_s && out_last_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DUMP;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
        drain_s = 8'd0;
      end
    endcase
  end

  // State register, registered run outputs and the saturating cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      drain_r  <= 8'd0;
      cpu_en_r <= 1'b0;
      done_r   <= 1'b0;
      cycle_r  <= 32'd0;
    end else begin
      state_r  <= state_s;
      drain_r  <= drain_s;
      cpu_en_r <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r   <= (state_s == ST_DONE);
      if ((state_r == ST_IDLE) && start) begin
        cycle_r <= 32'd0;
      end else if (cpu_en_r && (cycle_r != 32'hFFFF_FFFF)) begin
        cycle_r <= cycle_r + 32'd1;
      end else begin
        cycle_r <= cycle_r;
      end
    end
  end

  // Read strobe/address generation and in-flight tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_r     <= 1'b0;
      addr_r      <= '0;
      rd_last_r   <= 1'b0;
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      rd_cnt_r    <= '0;
      cred_r      <= 2'd0;
    end else begin
      rd_en_r     <= issue_s;
      pend_r      <= rd_en_r;
      pend_last_r <= rd_last_r;
      cred_r      <= cred_avail_s + {1'b0, issue_s};
      if (state_r == ST_IDLE) begin
        rd_cnt_r  <= '0;
        rd_last_r <= 1'b0;
      end else if (issue_s) begin
        addr_r    <= rd_cnt_r[ADDR_W-1:0];
        rd_last_r <= (rd_cnt_r == LAST_IDX);
        rd_cnt_r  <= rd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        rd_last_r <= 1'b0;
      end
    end
  end

  // Output register plus two-entry skid buffer for words returning while the
  // sink stalls; the output register only changes when it is free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= 32'd0;
      out_last_r   <= 1'b0;
      sk_data_r[0] <= 32'd0;
      sk_data_r[1] <= 32'd0;
      sk_last_r[0] <= 1'b0;
      sk_last_r[1] <= 1'b0;
      sk_wp_r      <= 1'b0;
      sk_rp_r      <= 1'b0;
      sk_cnt_r     <= 2'd0;
    end else begin
      if (out_free_s) begin
        if (sk_cnt_r != 2'd0) begin
          out_valid_r <= 1'b1;
          out_data_r  <= sk_data_r[sk_rp_r];
          out_last_r  <= sk_last_r[sk_rp_r];
        end else if (pend_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= bus.mem_rdata;
          out_last_r  <= pend_last_r;
        end else begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (push_s) begin
        sk_data_r[sk_wp_r] <= bus.mem_rdata;
        sk_last_r[sk_wp_r] <= pend_last_r;
        sk_wp_r            <= ~sk_wp_r;
      end else begin
        sk_wp_r <= sk_wp_r;
      end
      if (pop_s) begin
        sk_rp_r <= ~sk_rp_r;
      end else begin
        sk_rp_r <= sk_rp_r;
      end
      sk_cnt_r <= sk_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  assign cpu_en         = cpu_en_r;
  assign done           = done_r;
  assign cycle_count    = cycle_r;
  assign bus.mem_rd_en  = rd_en_r;
  assign bus.mem_addr   = addr_r;
  assign bus.dump_valid = out_valid_r;
  assign bus.dump_data  = out_data_r;
  assign bus.dump_last  = out_last_r;

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter HALT_INSTR, default 32'hFFFF_FFFF, the instruction word in ID that ends the program.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 10, the number of cycles the pipeline keeps running after halt detection (legal range 1..255).
REQ-003 SHALL have parameter MEM_DEPTH, default 512, the number of data-memory words to dump.
REQ-004 SHALL have parameter ADDR_W, default 9, the data-memory address width, with MEM_DEPTH <= 2**ADDR_W.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin program execution.
REQ-008 SHALL have port instr_id  input  32  instruction currently in the CPU ID stage.
REQ-009 SHALL have port cpu_en  output  1  CPU clock-enable; the pipeline advances only when it is 1.
REQ-010 SHALL have port mem_rd_en  output  1  data-memory debug read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  data-memory debug read address.
REQ-012 SHALL have port mem_rdata  input  32  data-memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port dump_valid  output  1  dump word available.
REQ-014 SHALL have port dump_ready  input  1  sink accepts the dump word.
REQ-015 SHALL have port dump_data  output  32  dump word.
REQ-016 SHALL have port dump_last  output  1  the current dump word is word MEM_DEPTH-1.
REQ-017 SHALL have port done  output  1  run and dump complete.
REQ-018 SHALL have port cycle_count  output  32  number of cpu_en=1 cycles since start.

Function
REQ-019 SHALL implement the states IDLE, RUN, DRAIN, DUMP and DONE.
REQ-020 IDLE: cpu_en=0; when start=1, the block SHALL move to RUN on the next edge and clear cycle_count to 0.
REQ-021 RUN: cpu_en=1; when instr_id==HALT_INSTR, the block SHALL move to DRAIN and load the drain counter with DRAIN_CYCLES.
REQ-022 DRAIN: cpu_en SHALL stay 1 for exactly DRAIN_CYCLES cycles after the halt-detect cycle, then the block SHALL move to DUMP with cpu_en=0.
REQ-023 DRAIN: instr_id SHALL be ignored, so repeated halt words do not reload the counter.
REQ-024 cycle_count SHALL increment by 1 on every cycle with cpu_en=1 and SHALL saturate at 32'hFFFF_FFFF; it SHALL hold its value in DUMP and DONE.
REQ-025 DUMP: the block SHALL issue reads at addresses 0..MEM_DEPTH-1 in ascending order, one per mem_rd_en pulse, with mem_addr valid while mem_rd_en=1.
REQ-026 A read SHALL be issued only if, in the following cycle, the output register will be empty or its contents consumed (dump_valid=0, or dump_valid=1 and dump_ready=1), so no data is lost or duplicated.
REQ-027 dump_valid SHALL rise the cycle after mem_rd_en; dump_data SHALL capture mem_rdata at that point.
REQ-028 While dump_valid=1 and dump_ready=0, dump_data, dump_last and dump_valid SHALL hold stable.
REQ-029 With dump_ready held at 1, the block SHALL sustain one word per cycle (back-to-back reads).
REQ-030 dump_last SHALL be 1 only alongside the word read from address MEM_DEPTH-1.
REQ-031 On the dump_valid && dump_ready && dump_last handshake, the block SHALL move to DONE.
REQ-032 DONE: done=1, cpu_en=0, mem_rd_en=0 and dump_valid=0, held until reset.
REQ-033 start SHALL be ignored in every state except IDLE.
REQ-034 If instr_id==HALT_INSTR on the first RUN cycle, the block SHALL still enter DRAIN normally.

Reset
REQ-035 reset=0 SHALL asynchronously force IDLE: cpu_en=0, mem_rd_en=0, mem_addr=0, dump_valid=0, dump_data=0, dump_last=0, done=0, cycle_count=0, drain counter=0.
REQ-036 A reset asserted mid-DRAIN or mid-DUMP SHALL abort the operation; after reset the block SHALL leave IDLE only on a new start.
REQ-037 Reset deassertion SHALL take effect on the next rising clk.

Verification
REQ-038 Scenario: start, halt word seen on RUN cycle 20 -> cpu_en=1 for exactly 20+10 cycles, then cycle_count=30 and the first mem_rd_en at addr 0.
REQ-039 Scenario: memory preloaded with word i = i*4, dump_ready=1 -> 512 consecutive dump_valid cycles carrying 0,4,...,2044, dump_last only on 2044, done=1 on the following cycle.
REQ-040 Scenario: dump_ready toggled randomly -> the sink receives exactly 512 words in order with no duplicates, and data stays stable while stalled.
REQ-041 Scenario: reset pulsed at dump word 100 -> all outputs return to reset values immediately; a fresh start reruns and dumps from addr 0.
REQ-042 Scenario: start asserted in RUN, DUMP and DONE -> no effect; halt word repeated during DRAIN -> drain length stays 10.
REQ-043 Scenario: DRAIN_CYCLES=1, halt on the first RUN cycle -> cpu_en=1 for exactly 2 cycles and cycle_count=2.
